// File: rtl/mips_muldiv_unit_pkg.sv
// Shared opcode/state types and constants for the MIPS HI/LO multiply-divide unit.
package mips_pkg;

    localparam int unsigned MULDIV_OP_W = 3;
    localparam logic [MULDIV_OP_W-1:0] MTHI_CODE = 3'd4;
    localparam logic [MULDIV_OP_W-1:0] MTLO_CODE = 3'd5;

    typedef enum logic [MULDIV_OP_W-1:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = MTHI_CODE,
        OP_MTLO  = MTLO_CODE
    } muldiv_op_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } muldiv_state_t;

    // Signed variants work on magnitudes and fix the sign on commit.
    function automatic logic op_is_signed(input logic [MULDIV_OP_W-1:0] op);
        return (op == OP_MULT) || (op == OP_DIV);
    endfunction

endpackage

// File: rtl/mips_muldiv_unit_if.sv
// Request/result bundle between an issuing pipeline and the multiply-divide unit.
interface mips_muldiv_unit_if
    import mips_pkg::*;
#(
    parameter int unsigned XLEN = 32
) ();

    logic                   start;
    logic [MULDIV_OP_W-1:0] op;
    logic [XLEN-1:0]        rs_val;
    logic [XLEN-1:0]        rt_val;
    logic                   busy;
    logic                   done;
    logic                   div_by_zero;
    logic [XLEN-1:0]        hi;
    logic [XLEN-1:0]        lo;

    modport master (
        output start, op, rs_val, rt_val,
        input  busy, done, div_by_zero, hi, lo
    );

    modport slave (
        input  start, op, rs_val, rt_val,
        output busy, done, div_by_zero, hi, lo
    );

endinterface

// File: rtl/mips_muldiv_unit.sv
// Iterative MIPS multiply/divide unit: radix-2 shift-add multiply, restoring divide,
// and the architectural HI/LO registers with MTHI/MTLO writes.
module mips_muldiv_unit
    import mips_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned CNT_W = $clog2(XLEN) + 1
) (
    input  logic                   clk,
    input  logic                   rst_b,
    input  logic                   start,
    input  logic [MULDIV_OP_W-1:0] op,
    input  logic [XLEN-1:0]        rs_val,
    input  logic [XLEN-1:0]        rt_val,
    output logic                   busy,
    output logic                   done,
    output logic                   div_by_zero,
    output logic [XLEN-1:0]        hi,
    output logic [XLEN-1:0]        lo
);

    localparam int unsigned WW = 2 * XLEN;

    muldiv_state_t    state_q, state_d;
    muldiv_op_t       op_q, op_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [XLEN-1:0]  opnd_q, opnd_d;
    logic [WW-1:0]    work_q, work_d;
    logic             q_neg_q, q_neg_d;
    logic             r_neg_q, r_neg_d;
    logic             dbz_q, dbz_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             div_by_zero_q, div_by_zero_d;
    logic [XLEN-1:0]  hi_q, hi_d;
    logic [XLEN-1:0]  lo_q, lo_d;

    logic             a_neg_c, b_neg_c, last_c, is_div_c;
    logic [XLEN:0]    mul_sum_c, div_sh_c, div_diff_c;
    logic [WW-1:0]    mul_nx_c, div_nx_c, iter_nx_c, prod_fix_c;
    logic [XLEN-1:0]  quot_fix_c, rem_fix_c;

    function automatic logic [XLEN-1:0] mag(input logic [XLEN-1:0] v, input logic neg);
        return neg ? XLEN'(-v) : v;
    endfunction

    // work_q holds {acc, multiplier} for multiply and {remainder, quotient} for divide.
    always_comb begin : iter_dp
        a_neg_c    = op_is_signed(op) & rs_val[XLEN-1];
        b_neg_c    = op_is_signed(op) & rt_val[XLEN-1];

        mul_sum_c  = {1'b0, work_q[WW-1:XLEN]} + (work_q[0] ? {1'b0, opnd_q} : '0);
        mul_nx_c   = {mul_sum_c, work_q[XLEN-1:1]};

        div_sh_c   = work_q[WW-1:XLEN-1];
        div_diff_c = div_sh_c - {1'b0, opnd_q};
        div_nx_c   = div_diff_c[XLEN] ? {div_sh_c[XLEN-1:0], work_q[XLEN-2:0], 1'b0}
                                      : {div_diff_c[XLEN-1:0], work_q[XLEN-2:0], 1'b1};

        iter_nx_c  = (state_q == ST_DIV) ? div_nx_c : mul_nx_c;
        prod_fix_c = q_neg_q ? WW'(-iter_nx_c) : iter_nx_c;
        quot_fix_c = q_neg_q ? XLEN'(-iter_nx_c[XLEN-1:0]) : iter_nx_c[XLEN-1:0];
        rem_fix_c  = r_neg_q ? XLEN'(-iter_nx_c[WW-1:XLEN]) : iter_nx_c[WW-1:XLEN];

        last_c     = (cnt_q == CNT_W'(XLEN - 1));
        is_div_c   = (op_q == OP_DIV) || (op_q == OP_DIVU);
    end

    always_comb begin : fsm_next
        state_d       = state_q;
        op_d          = op_q;
        cnt_d         = cnt_q;
        opnd_d        = opnd_q;
        work_d        = work_q;
        q_neg_d       = q_neg_q;
        r_neg_d       = r_neg_q;
        dbz_d         = dbz_q;
        hi_d          = hi_q;
        lo_d          = lo_q;
        done_d        = 1'b0;
        div_by_zero_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    case (op)
                        OP_MULT, OP_MULTU: begin
                            state_d = ST_MUL;
                            op_d    = muldiv_op_t'(op);
                            cnt_d   = '0;
                            opnd_d  = mag(rs_val, a_neg_c);
                            work_d  = {XLEN'(0), mag(rt_val, b_neg_c)};
                            q_neg_d = a_neg_c ^ b_neg_c;
                            r_neg_d = 1'b0;
                            dbz_d   = 1'b0;
                        end
                        OP_DIV, OP_DIVU: begin
                            op_d    = muldiv_op_t'(op);
                            cnt_d   = '0;
                            opnd_d  = mag(rt_val, b_neg_c);
                            work_d  = {XLEN'(0), mag(rs_val, a_neg_c)};
                            q_neg_d = a_neg_c ^ b_neg_c;
                            r_neg_d = a_neg_c;
                            if (rt_val == '0) begin
                                // Divide by zero short-circuits straight to the commit cycle.
                                state_d = ST_FIN;
                                dbz_d   = 1'b1;
                                hi_d    = rs_val;
                                lo_d    = '1;
                            end else begin
                                state_d = ST_DIV;
                                dbz_d   = 1'b0;
                            end
                        end
                        OP_MTHI: begin
                            state_d = ST_FIN;
                            op_d    = OP_MTHI;
                            dbz_d   = 1'b0;
                            hi_d    = rs_val;
                        end
                        OP_MTLO: begin
                            state_d = ST_FIN;
                            op_d    = OP_MTLO;
                            dbz_d   = 1'b0;
                            lo_d    = rs_val;
                        end
                        default: ;
                    endcase
                end
            end

            ST_MUL, ST_DIV: begin
                work_d = iter_nx_c;
                cnt_d  = cnt_q + 1'b1;
                if (last_c) begin
                    state_d = ST_FIN;
                    if (is_div_c) begin
                        hi_d = rem_fix_c;
                        lo_d = quot_fix_c;
                    end else begin
                        hi_d = prod_fix_c[WW-1:XLEN];
                        lo_d = prod_fix_c[XLEN-1:0];
                    end
                end
            end

            ST_FIN: begin
                state_d       = ST_IDLE;
                done_d        = 1'b1;
                div_by_zero_d = dbz_q;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q       <= ST_IDLE;
            op_q          <= OP_MULT;
            cnt_q         <= '0;
            opnd_q        <= '0;
            work_q        <= '0;
            q_neg_q       <= 1'b0;
            r_neg_q       <= 1'b0;
            dbz_q         <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            hi_q          <= '0;
            lo_q          <= '0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            cnt_q         <= cnt_d;
            opnd_q        <= opnd_d;
            work_q        <= work_d;
            q_neg_q       <= q_neg_d;
            r_neg_q       <= r_neg_d;
            dbz_q         <= dbz_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            div_by_zero_q <= div_by_zero_d;
            hi_q          <= hi_d;
            lo_q          <= lo_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule

// File: tb/tb_mips_muldiv_unit.sv
// Scoreboard bench for mips_muldiv_unit: directed vectors push expected HI/LO and latency,
// a monitor pops and compares on every done pulse.
module tb_mips_muldiv_unit;
    import mips_pkg::*;

    localparam int unsigned XLEN = 32;
    localparam int unsigned LAT_ITER = XLEN + 1;

    typedef struct {
        string       name;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int unsigned lat;
        int unsigned acc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_b;
    int unsigned cyc = 0;
    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    exp_t        sb_q[$];
    logic [31:0] m_hi = '0;
    logic [31:0] m_lo = '0;

    mips_muldiv_unit_if #(.XLEN(XLEN)) mif ();

    mips_muldiv_unit #(.XLEN(XLEN)) dut (
        .clk         (clk),
        .rst_b       (rst_b),
        .start       (mif.start),
        .op          (mif.op),
        .rs_val      (mif.rs_val),
        .rt_val      (mif.rt_val),
        .busy        (mif.busy),
        .done        (mif.done),
        .div_by_zero (mif.div_by_zero),
        .hi          (mif.hi),
        .lo          (mif.lo)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mif.done === 1'b1) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_done: got done=1, expected none (cycle %0d)", cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check({e.name, ".hi"},   mif.hi, e.hi);
                check({e.name, ".lo"},   mif.lo, e.lo);
                check({e.name, ".dbz"},  mif.div_by_zero, e.dbz);
                check({e.name, ".lat"},  cyc - e.acc, e.lat);
                check({e.name, ".busy"}, mif.busy, 1'b0);
            end
        end
    end

    task automatic do_op(input string nm, input logic [2:0] o, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] eh, input logic [31:0] el,
                         input logic ed, input int unsigned lat, input bit poke);
        exp_t        e;
        logic [31:0] prev_hi, prev_lo;
        bit          seen;
        @(negedge clk);
        mif.start  = 1'b1;
        mif.op     = o;
        mif.rs_val = a;
        mif.rt_val = b;
        e.name = nm; e.hi = eh; e.lo = el; e.dbz = ed; e.lat = lat; e.acc = cyc + 1;
        sb_q.push_back(e);
        prev_hi = m_hi;
        prev_lo = m_lo;
        m_hi = eh;
        m_lo = el;
        @(negedge clk);
        mif.start  = 1'b0;
        mif.op     = 3'($urandom_range(0, 7));
        mif.rs_val = $urandom;
        mif.rt_val = $urandom;
        check({nm, ".busy_after_accept"}, mif.busy, 1'b1);
        if (poke) begin
            // A start while busy must be ignored.
            mif.start  = 1'b1;
            mif.op     = OP_MULTU;
            mif.rs_val = 32'd2;
            mif.rt_val = 32'd3;
        end
        seen = 1'b0;
        for (int i = 0; i < 80 && !seen; i++) begin
            @(negedge clk);
            mif.start = 1'b0;
            if (lat > 1 && i == 10) begin
                check({nm, ".hi_stable"}, mif.hi, prev_hi);
                check({nm, ".lo_stable"}, mif.lo, prev_lo);
            end
            seen = (mif.done === 1'b1);
        end
        if (!seen) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.timeout: got no done within 80 cycles, expected done", nm);
            void'(sb_q.pop_back());
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_b      = 1'b1;
        mif.start  = 1'b0;
        mif.op     = OP_MULT;
        mif.rs_val = '0;
        mif.rt_val = '0;
        repeat (3) @(negedge clk);
        check("reset.busy", mif.busy, 1'b0);
        check("reset.done", mif.done, 1'b0);
        check("reset.dbz",  mif.div_by_zero, 1'b0);
        check("reset.hi",   mif.hi, 32'h0);
        check("reset.lo",   mif.lo, 32'h0);
        rst_b = 1'b0;

        do_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 1'b0, LAT_ITER, 1'b0);
        do_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd7,          32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0, LAT_ITER, 1'b0);
        do_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0, LAT_ITER, 1'b0);
        do_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 1'b0, LAT_ITER, 1'b0);
        do_op("divu_zero", OP_DIVU,  32'd100,       32'd0,          32'h0000_0064, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
        do_op("mtlo_poke", OP_MTLO,  32'h1234_5678, 32'd0,          m_hi,          32'h1234_5678, 1'b0, 1, 1'b1);
        repeat (40) @(negedge clk);
        check("mtlo_poke.idle_busy", mif.busy, 1'b0);
        check("mtlo_poke.idle_lo",   mif.lo, 32'h1234_5678);
        check("mtlo_poke.idle_hi",   mif.hi, 32'h0000_0064);

        do_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'h0000_0000, 1'b0, LAT_ITER, 1'b1);
        do_op("divu_big",  OP_DIVU,  32'hFFFF_FFFF, 32'h0000_0010,  32'h0000_000F, 32'h0FFF_FFFF, 1'b0, LAT_ITER, 1'b1);
        do_op("div_pn",    OP_DIV,   32'd7,         32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 1'b0, LAT_ITER, 1'b0);
        do_op("div_zero_s",OP_DIV,   32'hFFFF_FFFB, 32'd0,          32'hFFFF_FFFB, 32'hFFFF_FFFF, 1'b1, 1, 1'b0);
        do_op("mthi",      OP_MTHI,  32'hAABB_CCDD, 32'd0,          32'hAABB_CCDD, m_lo,          1'b0, 1, 1'b0);

        // Reserved opcode is ignored.
        @(negedge clk);
        mif.start = 1'b1;
        mif.op    = 3'd6;
        @(negedge clk);
        mif.start = 1'b0;
        check("reserved.busy", mif.busy, 1'b0);
        repeat (3) @(negedge clk);
        check("reserved.hi", mif.hi, m_hi);
        check("reserved.lo", mif.lo, m_lo);

        // Reset mid-multiply, with a start presented during reset.
        @(negedge clk);
        mif.start  = 1'b1;
        mif.op     = OP_MULTU;
        mif.rs_val = 32'hFFFF_FFFF;
        mif.rt_val = 32'hFFFF_FFFF;
        @(negedge clk);
        mif.start = 1'b0;
        repeat (10) @(negedge clk);
        check("midrst.busy_before", mif.busy, 1'b1);
        rst_b      = 1'b1;
        mif.start  = 1'b1;
        mif.op     = OP_MTHI;
        mif.rs_val = 32'hDEAD_BEEF;
        @(negedge clk);
        rst_b     = 1'b0;
        mif.start = 1'b0;
        check("midrst.busy", mif.busy, 1'b0);
        check("midrst.done", mif.done, 1'b0);
        check("midrst.hi",   mif.hi, 32'h0);
        check("midrst.lo",   mif.lo, 32'h0);
        m_hi = '0;
        m_lo = '0;
        repeat (40) @(negedge clk);
        check("midrst.idle_busy", mif.busy, 1'b0);

        do_op("divu_9_4",  OP_DIVU,  32'd9,         32'd4,          32'h0000_0001, 32'h0000_0002, 1'b0, LAT_ITER, 1'b0);
        do_op("multu_sh",  OP_MULTU, 32'h1234_5678, 32'h0000_0010,  32'h0000_0001, 32'h2345_6780, 1'b0, LAT_ITER, 1'b0);

        repeat (5) @(negedge clk);
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
